vga_text_blitter: RTL and testbench

//  Command-driven engine on main_clk that fills or copies rectangles of text

---
 rtl/vga_text_blitter.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_vga_text_blitter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : vga_text_blitter
// Description : Command-driven FILL / COPY engine for rectangles of 3-byte
//               text cells in VGA memory. Cell i lives at byte 3*i:
//               +0 char, +1 foreground, +2 background.
// Revision    : 1.0  initial release
// ============================================================================
module vga_text_blitter #(
    parameter int READ_LATENCY   = 2,
    parameter int LAST_TEXT_ADDR = 20475
) (
    input  logic        main_clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [6:0]  cmd_x,
    input  logic [6:0]  cmd_y,
    input  logic [6:0]  cmd_w,
    input  logic [6:0]  cmd_h,
    input  logic [6:0]  cmd_sx,
    input  logic [6:0]  cmd_sy,
    input  logic [7:0]  cmd_char,
    input  logic [7:0]  cmd_fg,
    input  logic [7:0]  cmd_bg,
    input  logic [6:0]  columns,
    input  logic [6:0]  rows,
    output logic        done,
    output logic        error,
    output logic        mem_req,
    input  logic        mem_gnt,
    output logic        mem_do_write,
    output logic        mem_do_byte_op,
    output logic [14:0] mem_addr,
    output logic [15:0] mem_write_data,
    input  logic [15:0] mem_read_data
);

    localparam logic [2:0]  c_IDLE     = 3'd0;
    localparam logic [2:0]  c_CHECK    = 3'd1;
    localparam logic [2:0]  c_REQ      = 3'd2;
    localparam logic [2:0]  c_FILL     = 3'd3;
    localparam logic [2:0]  c_CPY_RD   = 3'd4;
    localparam logic [2:0]  c_CPY_WAIT = 3'd5;
    localparam logic [2:0]  c_CPY_WR   = 3'd6;
    localparam logic [2:0]  c_DONE     = 3'd7;

    localparam logic [17:0] c_LAST_ADDR = 18'(LAST_TEXT_ADDR);
    localparam logic [7:0]  c_WAIT_LAST = 8'(READ_LATENCY - 1);

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;

    logic        r_op;
    logic [6:0]  r_x, r_y, r_w, r_h, r_sx, r_sy;
    logic [7:0]  r_char, r_fg, r_bg;
    logic [6:0]  r_cols, r_rows;
    logic [14:0] r_stride;
    logic [14:0] r_dst_base, r_src_base, r_dst_ptr, r_src_ptr;
    logic [6:0]  r_col, r_row;
    logic [1:0]  r_byte;
    logic [7:0]  r_wait_cnt;
    logic        r_bad;
    logic        r_err;
    logic        r_skip;

    // ------------------------------------------------------------------
    // Command legality, evaluated in the single CHECK cycle
    // ------------------------------------------------------------------
    logic [7:0]  w_dst_end_x, w_dst_end_y, w_src_end_x, w_src_end_y;
    logic [15:0] w_dst_idx, w_src_idx, w_dst_last_idx, w_src_last_idx;
    logic [17:0] w_dst_last_addr, w_src_last_addr;
    logic [14:0] w_dst_addr0, w_src_addr0;
    logic        w_dst_ovf, w_src_ovf, w_reject, w_empty;

    assign w_dst_end_x     = {1'b0, r_x}  + {1'b0, r_w};
    assign w_dst_end_y     = {1'b0, r_y}  + {1'b0, r_h};
    assign w_src_end_x     = {1'b0, r_sx} + {1'b0, r_w};
    assign w_src_end_y     = {1'b0, r_sy} + {1'b0, r_h};
    assign w_dst_idx       = 16'(r_y)  * 16'(r_cols) + 16'(r_x);
    assign w_src_idx       = 16'(r_sy) * 16'(r_cols) + 16'(r_sx);
    assign w_dst_last_idx  = 16'(w_dst_end_y - 8'd1) * 16'(r_cols) + 16'(w_dst_end_x - 8'd1);
    assign w_src_last_idx  = 16'(w_src_end_y - 8'd1) * 16'(r_cols) + 16'(w_src_end_x - 8'd1);
    assign w_dst_last_addr = 18'(w_dst_last_idx) * 18'd3 + 18'd2;
    assign w_src_last_addr = 18'(w_src_last_idx) * 18'd3 + 18'd2;
    // Only consumed once the command is legal, so the index fits in 13 bits
    assign w_dst_addr0     = 15'(w_dst_idx) * 15'd3;
    assign w_src_addr0     = 15'(w_src_idx) * 15'd3;

    assign w_dst_ovf = (w_dst_end_x > {1'b0, r_cols}) || (w_dst_end_y > {1'b0, r_rows}) ||
                       (w_dst_last_addr > c_LAST_ADDR);
    assign w_src_ovf = (w_src_end_x > {1'b0, r_cols}) || (w_src_end_y > {1'b0, r_rows}) ||
                       (w_src_last_addr > c_LAST_ADDR);
    // Copies always run ascending, so the destination may not sit above the source
    assign w_reject  = w_dst_ovf || (r_op && (w_src_ovf || (w_dst_idx > w_src_idx)));
    assign w_empty   = (r_w == 7'd0) || (r_h == 7'd0);

    // ------------------------------------------------------------------
    // Walk position and write strobe
    // ------------------------------------------------------------------
    logic       w_last_byte, w_last_col, w_last_row, w_last;
    logic       w_write;
    logic [7:0] w_rd_byte;
    logic [7:0] w_fill_byte;

    assign w_last_byte = (r_byte == 2'd2);
    assign w_last_col  = (r_col == r_w - 7'd1);
    assign w_last_row  = (r_row == r_h - 7'd1);
    assign w_last      = w_last_byte && w_last_col && w_last_row;
    // A copy write only goes out if its whole read window kept the grant
    assign w_write     = mem_gnt && ((r_state == c_FILL) || ((r_state == c_CPY_WR) && !r_bad));
    assign w_rd_byte   = r_src_ptr[0] ? mem_read_data[15:8] : mem_read_data[7:0];

    always_comb begin
        w_fill_byte = r_bg;
        case (r_byte)
            2'd0:    w_fill_byte = r_char;
            2'd1:    w_fill_byte = r_fg;
            default: w_fill_byte = r_bg;
        endcase
    end

    // State register
    always_ff @(posedge main_clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next_state;
    end

    // Next-state and output decode
    always_comb begin
        w_next_state   = r_state;
        cmd_ready      = 1'b0;
        done           = 1'b0;
        error          = 1'b0;
        mem_req        = 1'b0;
        mem_addr       = 15'd0;
        mem_write_data = 16'd0;
        case (r_state)
            c_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next_state = c_CHECK;
            end
            c_CHECK: begin
                if (w_empty || w_reject) w_next_state = c_DONE;
                else                     w_next_state = c_REQ;
            end
            c_REQ: begin
                mem_req  = 1'b1;
                mem_addr = r_op ? r_src_ptr : r_dst_ptr;
                if (mem_gnt) w_next_state = r_op ? c_CPY_RD : c_FILL;
            end
            c_FILL: begin
                mem_req        = 1'b1;
                mem_addr       = r_dst_ptr;
                mem_write_data = {w_fill_byte, w_fill_byte};
                if (w_write && w_last) w_next_state = c_DONE;
            end
            c_CPY_RD: begin
                mem_req  = 1'b1;
                mem_addr = r_src_ptr;
                if (mem_gnt) w_next_state = (READ_LATENCY <= 1) ? c_CPY_WR : c_CPY_WAIT;
            end
            c_CPY_WAIT: begin
                mem_req  = 1'b1;
                mem_addr = r_src_ptr;
                if (r_wait_cnt >= c_WAIT_LAST) w_next_state = c_CPY_WR;
            end
            c_CPY_WR: begin
                mem_req        = 1'b1;
                mem_addr       = r_dst_ptr;
                mem_write_data = {w_rd_byte, w_rd_byte};
                // Without a write this byte is simply read again
                if (w_write && w_last) w_next_state = c_DONE;
                else                   w_next_state = c_CPY_RD;
            end
            c_DONE: begin
                done         = 1'b1;
                error        = r_err;
                mem_req      = !r_skip;
                w_next_state = c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    assign mem_do_write   = w_write;
    assign mem_do_byte_op = mem_req;

    // Command capture, pointer setup and row-major walk over the rectangle
    always_ff @(posedge main_clk) begin
        if (reset) begin
            r_op       <= 1'b0;
            r_x        <= 7'd0;
            r_y        <= 7'd0;
            r_w        <= 7'd0;
            r_h        <= 7'd0;
            r_sx       <= 7'd0;
            r_sy       <= 7'd0;
            r_char     <= 8'd0;
            r_fg       <= 8'd0;
            r_bg       <= 8'd0;
            r_cols     <= 7'd0;
            r_rows     <= 7'd0;
            r_stride   <= 15'd0;
            r_dst_base <= 15'd0;
            r_src_base <= 15'd0;
            r_dst_ptr  <= 15'd0;
            r_src_ptr  <= 15'd0;
            r_col      <= 7'd0;
            r_row      <= 7'd0;
            r_byte     <= 2'd0;
            r_wait_cnt <= 8'd0;
            r_bad      <= 1'b0;
            r_err      <= 1'b0;
            r_skip     <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (cmd_valid) begin
                        r_op     <= cmd_op;
                        r_x      <= cmd_x;
                        r_y      <= cmd_y;
                        r_w      <= cmd_w;
                        r_h      <= cmd_h;
                        r_sx     <= cmd_sx;
                        r_sy     <= cmd_sy;
                        r_char   <= cmd_char;
                        r_fg     <= cmd_fg;
                        r_bg     <= cmd_bg;
                        r_cols   <= columns;
                        r_rows   <= rows;
                        r_stride <= 15'(columns) * 15'd3;
                    end
                end
                c_CHECK: begin
                    r_skip     <= w_empty || w_reject;
                    r_err      <= !w_empty && w_reject;
                    r_dst_base <= w_dst_addr0;
                    r_dst_ptr  <= w_dst_addr0;
                    r_src_base <= w_src_addr0;
                    r_src_ptr  <= w_src_addr0;
                    r_col      <= 7'd0;
                    r_row      <= 7'd0;
                    r_byte     <= 2'd0;
                end
                c_CPY_RD: begin
                    if (mem_gnt) begin
                        r_bad      <= 1'b0;
                        r_wait_cnt <= 8'd1;
                    end
                end
                c_CPY_WAIT: begin
                    if (!mem_gnt) r_bad <= 1'b1;
                    r_wait_cnt <= r_wait_cnt + 8'd1;
                end
                default: ;
            endcase

            if (w_write) begin
                if (!w_last_byte) begin
                    r_byte    <= r_byte + 2'd1;
                    r_dst_ptr <= r_dst_ptr + 15'd1;
                    r_src_ptr <= r_src_ptr + 15'd1;
                end else if (!w_last_col) begin
                    r_byte    <= 2'd0;
                    r_col     <= r_col + 7'd1;
                    r_dst_ptr <= r_dst_ptr + 15'd1;
                    r_src_ptr <= r_src_ptr + 15'd1;
                end else begin
                    r_byte     <= 2'd0;
                    r_col      <= 7'd0;
                    r_row      <= r_row + 7'd1;
                    r_dst_base <= r_dst_base + r_stride;
                    r_src_base <= r_src_base + r_stride;
                    r_dst_ptr  <= r_dst_base + r_stride;
                    r_src_ptr  <= r_src_base + r_stride;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vga_text_blitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_text_blitter
// Description : Directed self-checking bench for vga_text_blitter with a
//               byte memory model behind a 2-cycle shared read port.
// Revision    : 1.0  initial release
// ============================================================================
module tb_vga_text_blitter;

    localparam int MEM_BYTES = 20480;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_op = 1'b0;
    logic [6:0]  cmd_x = 7'd0, cmd_y = 7'd0, cmd_w = 7'd0, cmd_h = 7'd0;
    logic [6:0]  cmd_sx = 7'd0, cmd_sy = 7'd0;
    logic [7:0]  cmd_char = 8'd0, cmd_fg = 8'd0, cmd_bg = 8'd0;
    logic [6:0]  columns = 7'd80, rows = 7'd30;
    logic        done, error, mem_req, mem_do_write, mem_do_byte_op;
    logic        mem_gnt = 1'b1;
    logic [14:0] mem_addr;
    logic [15:0] mem_write_data;
    logic [15:0] mem_read_data;

    vga_text_blitter #(.READ_LATENCY(2), .LAST_TEXT_ADDR(20475)) dut (
        .main_clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_sx(cmd_sx), .cmd_sy(cmd_sy),
        .cmd_char(cmd_char), .cmd_fg(cmd_fg), .cmd_bg(cmd_bg),
        .columns(columns), .rows(rows),
        .done(done), .error(error),
        .mem_req(mem_req), .mem_gnt(mem_gnt),
        .mem_do_write(mem_do_write), .mem_do_byte_op(mem_do_byte_op),
        .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    // Memory model state
    logic [7:0]  mem [0:MEM_BYTES-1];
    logic [14:0] p1_addr = 15'd0, p2_addr = 15'd0;
    logic        p1_ok = 1'b0, p2_ok = 1'b0;
    logic        load_req = 1'b0;
    logic [14:0] wr_addr_q [$];
    logic [15:0] wr_data_q [$];
    int          wr_cnt = 0, req_cnt = 0, bad_strobe = 0;

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 7 + (i >> 8) * 13 + 3);
    endfunction

    // Shared port: a grant gap lets other traffic through and spoils reads in flight
    always @(posedge clk) begin
        p1_addr <= mem_addr;
        p1_ok   <= mem_req && mem_gnt;
        p2_addr <= p1_addr;
        p2_ok   <= p1_ok && mem_gnt;
        if (load_req) begin
            for (int i = 0; i < MEM_BYTES; i++) mem[i] <= pat(i);
        end else if (mem_req && mem_gnt && mem_do_write) begin
            if (int'(mem_addr) < MEM_BYTES) mem[mem_addr] <= mem_write_data[7:0];
            wr_addr_q.push_back(mem_addr);
            wr_data_q.push_back(mem_write_data);
            wr_cnt <= wr_cnt + 1;
        end
        if (mem_req) req_cnt <= req_cnt + 1;
        if (mem_do_write && !mem_gnt) bad_strobe <= bad_strobe + 1;
    end

    assign mem_read_data = (p2_ok && mem_gnt) ?
        {mem[{p2_addr[14:1], 1'b1}], mem[{p2_addr[14:1], 1'b0}]} : 16'hDEAD;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
        end
    endtask

    task automatic send(input logic op, input int x, input int y, input int w, input int h,
                        input int sx, input int sy, input logic [7:0] ch,
                        input logic [7:0] fg, input logic [7:0] bg);
        logic acc;
        cmd_op = op; cmd_x = 7'(x); cmd_y = 7'(y); cmd_w = 7'(w); cmd_h = 7'(h);
        cmd_sx = 7'(sx); cmd_sy = 7'(sy); cmd_char = ch; cmd_fg = fg; cmd_bg = bg;
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            acc = cmd_ready;
            @(posedge clk); #1;
            if (acc) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int max, output int cyc, output logic err);
        cyc = -1;
        err = 1'b0;
        for (int i = 1; i <= max; i++) begin
            @(posedge clk); #1;
            if (done) begin
                cyc = i;
                err = error;
                return;
            end
        end
    endtask

    task automatic load_mem();
        load_req = 1'b1;
        @(posedge clk); #1;
        load_req = 1'b0;
    endtask

    initial begin
        int   cyc, base, rbase, bad1, bad2, dsum;
        logic err;

        // Reset values
        @(posedge clk); #1;
        chk("rst cmd_ready", cmd_ready, 1);
        chk("rst done", done, 0);
        chk("rst error", error, 0);
        chk("rst mem_req", mem_req, 0);
        chk("rst mem_do_write", mem_do_write, 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_write_data", mem_write_data, 0);
        load_mem();
        reset = 1'b0;
        @(posedge clk); #1;

        // Basic FILL of two cells
        base = wr_cnt;
        send(1'b0, 0, 0, 2, 1, 0, 0, 8'h41, 8'hFF, 8'h00);
        chk("fill busy ready", cmd_ready, 0);
        wait_done(50, cyc, err);
        chk("fill cycles", cyc, 8);
        chk("fill error", err, 0);
        chk("fill count", wr_cnt - base, 6);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] b;
            b = (i % 3 == 0) ? 8'h41 : (i % 3 == 1) ? 8'hFF : 8'h00;
            chk("fill addr", wr_addr_q[base + i], i);
            chk("fill data", wr_data_q[base + i], {b, b});
        end
        @(posedge clk); #1;
        chk("ready after done", cmd_ready, 1);
        chk("done single pulse", done, 0);

        // Rejected: x+w beyond columns
        base = wr_cnt; rbase = req_cnt;
        send(1'b0, 78, 0, 3, 1, 0, 0, 8'h11, 8'h22, 8'h33);
        wait_done(20, cyc, err);
        chk("rej x cycles", cyc, 1);
        chk("rej x error", err, 1);
        @(posedge clk); #1;
        chk("rej error pulse", error, 0);
        chk("rej x writes", wr_cnt - base, 0);
        chk("rej x req", req_cnt - rbase, 0);

        // Empty rectangle: done without error or bus activity
        rbase = req_cnt;
        send(1'b0, 5, 5, 0, 3, 0, 0, 8'h11, 8'h22, 8'h33);
        wait_done(20, cyc, err);
        chk("empty cycles", cyc, 1);
        chk("empty error", err, 0);
        chk("empty req", req_cnt - rbase, 0);

        // COPY with destination above source
        send(1'b1, 0, 1, 1, 1, 0, 0, 8'h00, 8'h00, 8'h00);
        wait_done(20, cyc, err);
        chk("rej dst>src error", err, 1);

        // COPY whose source runs past the last column
        send(1'b1, 0, 0, 2, 1, 79, 0, 8'h00, 8'h00, 8'h00);
        wait_done(20, cyc, err);
        chk("rej src extent error", err, 1);

        // Last legal cell ends at 20474, the next one would reach 20477
        rows = 7'd127;
        base = wr_cnt;
        send(1'b0, 24, 85, 1, 1, 0, 0, 8'hA5, 8'h5A, 8'hC3);
        wait_done(20, cyc, err);
        chk("limit ok cycles", cyc, 5);
        chk("limit ok error", err, 0);
        chk("limit ok last addr", wr_addr_q[base + 2], 20474);
        send(1'b0, 25, 85, 1, 1, 0, 0, 8'hA5, 8'h5A, 8'hC3);
        wait_done(20, cyc, err);
        chk("limit over error", err, 1);
        rows = 7'd30;

        // FILL with the grant withdrawn for 5 cycles after the 2nd write
        base = wr_cnt;
        send(1'b0, 0, 2, 4, 1, 0, 0, 8'h55, 8'h0F, 8'h70);
        fork
            wait_done(60, cyc, err);
            begin
                for (int i = 0; i < 20; i++) begin
                    @(posedge clk); #1;
                    if (wr_cnt == base + 2) break;
                end
                mem_gnt = 1'b0;
                repeat (5) @(posedge clk);
                #1 mem_gnt = 1'b1;
            end
        join
        chk("gnt fill cycles", cyc, 19);
        chk("gnt fill count", wr_cnt - base, 12);
        bad1 = 0;
        for (int i = 0; i < 12; i++) begin
            logic [7:0] b;
            b = (i % 3 == 0) ? 8'h55 : (i % 3 == 1) ? 8'h0F : 8'h70;
            if (wr_addr_q[base + i] != 15'(480 + i) || wr_data_q[base + i] != {b, b}) bad1++;
        end
        chk("gnt fill sequence", bad1, 0);
        chk("no strobe without gnt", bad_strobe, 0);

        // COPY of one cell with the grant missing during the read wait
        base = wr_cnt;
        send(1'b1, 0, 4, 1, 1, 0, 5, 8'h00, 8'h00, 8'h00);
        fork
            wait_done(60, cyc, err);
            begin
                repeat (3) @(posedge clk);
                #1 mem_gnt = 1'b0;
                @(posedge clk);
                #1 mem_gnt = 1'b1;
            end
        join
        chk("reread cycles", cyc, 14);
        chk("reread count", wr_cnt - base, 3);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) chk("reread data", mem[960 + k], pat(1200 + k));

        // Scroll up one line: rows 1..29 move to rows 0..28
        load_mem();
        base = wr_cnt;
        send(1'b1, 0, 0, 80, 29, 0, 1, 8'h00, 8'h00, 8'h00);
        wait_done(25000, cyc, err);
        chk("scroll cycles", cyc, 20882);
        chk("scroll error", err, 0);
        chk("scroll count", wr_cnt - base, 6960);
        @(posedge clk); #1;
        bad1 = 0; bad2 = 0;
        for (int a = 0; a < 6960; a++) if (mem[a] !== pat(a + 240)) bad1++;
        for (int a = 6960; a < 7200; a++) if (mem[a] !== pat(a)) bad2++;
        chk("scroll body", bad1, 0);
        chk("scroll last row", bad2, 0);

        // Reset in the middle of a FILL
        send(1'b0, 0, 10, 10, 1, 0, 0, 8'h01, 8'h02, 8'h03);
        repeat (4) @(posedge clk);
        #1;
        chk("midfill req", mem_req, 1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort mem_req", mem_req, 0);
        chk("abort mem_do_write", mem_do_write, 0);
        chk("abort cmd_ready", cmd_ready, 1);
        chk("abort done", done, 0);
        reset = 1'b0;
        dsum = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done) dsum++;
        end
        chk("abort no done", dsum, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
